uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Buffered UART transmitter that drives the SoC UART0 `RsTx` pin consumed by the bench serial terminal. It accepts bytes from the peripheral register interface into a small FIFO, then serialises each byte as an 8-N-1 frame (optionally 8-E/O-1) at a programmable bit period. It is the stage directly upstream of the serial line and its terminal.

## Interface
- `FIFO_DEPTH`, default 16: FIFO entries, power of two, minimum 2.
- `HCLK`, input, 1: system clock; all state on rising edge.
- `HRESETn`, input, 1: asynchronous active-low reset.
- `en`, input, 1: transmitter enable; gates only the start of new frames.
- `prescale`, input, 16: bit period equals `prescale`+1 HCLK cycles.
- `wdata`, input, 8: byte to enqueue.
- `wr`, input, 1: enqueue strobe, one byte per asserted cycle.
- `ovf_clr`, input, 1: clears `ovf`.
- `parity_en`, input, 1: parity bit inserted (honoured only with macro).
- `parity_odd`, input, 1: 1 selects odd parity, 0 selects even (honoured only with macro).
- `tx`, output, 1: serial line, idles high.
- `full`, output, 1: FIFO holds `FIFO_DEPTH` bytes.
- `empty`, output, 1: FIFO holds 0 bytes.
- `level`, output, clog2(`FIFO_DEPTH`)+1: current occupancy.
- `busy`, output, 1: a frame is in progress (FSM not IDLE).
- `ovf`, output, 1: sticky flag set when a write is dropped.

## Operation
- Reset values: `tx`=1, `full`=0, `empty`=1, `level`=0, `busy`=0, `ovf`=0. The FIFO pointers clear and the FSM enters IDLE.
- FIFO write path:
  - A write with `wr`=1 and `full`=0 is accepted.
  - A write with `wr`=1 and `full`=1 is dropped and sets `ovf`. This holds even if a pop occurs in the same cycle, because `full` is the registered pre-edge value.
  - `ovf_clr` takes priority over a simultaneous set.
- Pop and write in the same cycle when not full: `level` is unchanged and both operations take effect.
- FSM states are IDLE, START, DATA, PARITY and STOP.
- IDLE: when `en`=1 and `empty`=0, pop the head byte, latch `prescale` and the parity controls, drive `tx`=0 and go to START.
- START: holds `tx`=0 for one bit period, then goes to DATA.
- DATA: sends 8 bits LSB first, one bit period each, using a 3-bit index. After bit 7 it goes to PARITY if parity is latched enabled, otherwise to STOP.
- PARITY: sends XOR of the data bits XOR `parity_odd` for one bit period, then goes to STOP.
- STOP: drives `tx`=1 for one bit period.
- At the end of STOP: if `en`=1 and the FIFO is non-empty, pop and go straight to START, giving back-to-back frames with no idle gap. Otherwise go to IDLE.
- A 16-bit down-counter is reloaded with the latched prescale at each bit boundary. A bit ends when the counter reads 0.
- Changes to `prescale` or parity inputs mid-frame have no effect until the next frame.
- Deasserting `en` mid-frame lets the current frame complete, and no further pop follows.
- Asserting reset mid-frame forces `tx`=1 immediately (asynchronous) and discards the FIFO contents.

## Timing
- All outputs are registered.
- Write accepted at edge k into an empty FIFO while IDLE with `en`=1: `level` becomes 1 at k, then `tx` falls and `busy` rises at edge k+1.
- Frame length is 10×(`prescale`+1) cycles, or 11×(`prescale`+1) cycles with parity.
- `prescale`=15 at a 100 MHz HCLK gives a 160 ns bit, which matches the bench terminal.
- `prescale`=0 gives one cycle per bit.
- `busy` falls on the edge that ends STOP unless a back-to-back frame follows.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state and its logic are compiled in, and `parity_en`/`parity_odd` are honoured.
- `UART_TX_PARITY_EN` undefined: the PARITY state is absent, both parity inputs are ignored (ports remain), and frames are always 8-N-1.

## Structure
- Package `uart_tx_pkg`: FSM state enum, `DATA_BITS`=8, and the prescale width constant 16.
- Sub-module `uart_byte_fifo`: synchronous FIFO with read/write pointers one bit wider than the address, plus `full`/`empty`/`level` outputs.
- Top level: FSM, bit counter, shift register and overflow flag.

## Test plan
- `prescale`=15, write 0x41 with parity compiled out:
  - `tx` pattern is 0,1,0,0,0,0,0,1,0,1, each bit 16 cycles.
  - The terminal prints "A" and `busy` spans 160 cycles.
- Write 17 bytes back-to-back with `en`=0:
  - `full`=1 and `level`=16 after the 16th write.
  - The 17th write sets `ovf`, and `ovf_clr` clears it.
- Then set `en`=1:
  - Exactly 16 frames are sent with no idle gap between frames.
  - `empty`=1 after the final STOP.
- Parity compiled in, write 0x41 with `parity_en`=1:
  - `parity_odd`=0 gives parity bit 0.
  - `parity_odd`=1 gives parity bit 1.
  - Frame is 11 bit periods.
- `prescale`=0, write 0xFF then 0x00: frames are 10 cycles each and bit boundaries are exact.
- Mid-frame events during DATA:
  - Changing `prescale` mid-frame leaves the current frame's timing unchanged.
  - Asserting `HRESETn`=0 mid-frame gives `tx`=1 and `level`=0 immediately, with no residual frame after release.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// Optional build macro: UART_TX_PARITY_EN adds the PARITY state.
package uart_tx_pkg;

    localparam int DATA_BITS  = 8;
    localparam int PRESCALE_W = 16;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} tx_state_e;
`endif

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with extra-MSB pointers; full/empty/level are registered.
module uart_byte_fifo #(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [7:0]  wdata,
    input  logic        pop,
    output logic [7:0]  rdata,
    output logic        full,
    output logic        empty,
    output logic [AW:0] level
);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wptr, rptr, wptr_n, rptr_n, level_n;
    logic        push_ok, pop_ok;

    // Accept/drop decisions use the registered flags from before the edge.
    always_comb begin
        push_ok = push & ~full;
        pop_ok  = pop & ~empty;
        wptr_n  = wptr + (AW+1)'(push_ok);
        rptr_n  = rptr + (AW+1)'(pop_ok);
        level_n = wptr_n - rptr_n;
    end

    assign rdata = mem[rptr[AW-1:0]];

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr[AW-1:0]] <= wdata;
    end

    // Pointers and status flags, all registered from next-state values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            wptr  <= wptr_n;
            rptr  <= rptr_n;
            level <= level_n;
            full  <= (level_n == (AW+1)'(DEPTH));
            empty <= (level_n == '0);
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding an 8-N-1 serialiser.
// Optional build macro: UART_TX_PARITY_EN enables the parity bit.
module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic                          en,
    input  logic [PRESCALE_W-1:0]         prescale,
    input  logic [7:0]                    wdata,
    input  logic                          wr,
    input  logic                          ovf_clr,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    output logic                          tx,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          busy,
    output logic                          ovf
);

    tx_state_e             state, state_n;
    logic [PRESCALE_W-1:0] cnt, cnt_n, presc_l, presc_l_n;
    logic [2:0]            idx, idx_n;
    logic [7:0]            sh, sh_n, rdata;
    logic                  tx_n, pop, bit_end, start_frame;

`ifdef UART_TX_PARITY_EN
    logic par_en_l, par_en_l_n, par_bit_l, par_bit_l_n;
`else
    logic unused_parity;
    assign unused_parity = parity_en ^ parity_odd;
`endif

    uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .push  (wr),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // Next-state, bit timing and serial data selection.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        presc_l_n = presc_l;
        idx_n     = idx;
        sh_n      = sh;
        tx_n      = tx;
        pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_en_l_n  = par_en_l;
        par_bit_l_n = par_bit_l;
`endif
        bit_end     = (cnt == '0);
        start_frame = en && !empty && (state == IDLE || (state == STOP && bit_end));

        if (state != IDLE && !bit_end) cnt_n = cnt - PRESCALE_W'(1);

        case (state)
            IDLE: tx_n = 1'b1;
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    tx_n    = sh[0];
                    sh_n    = sh >> 1;
                    idx_n   = '0;
                    cnt_n   = presc_l;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_n = presc_l;
                    if (idx == 3'(DATA_BITS-1)) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
`ifdef UART_TX_PARITY_EN
                        if (par_en_l) begin
                            state_n = PARITY;
                            tx_n    = par_bit_l;
                        end
`endif
                    end else begin
                        idx_n = idx + 3'd1;
                        tx_n  = sh[0];
                        sh_n  = sh >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                    cnt_n   = presc_l;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_n = IDLE;
                    tx_n    = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase

        // Frame launch is shared by IDLE and the back-to-back STOP exit.
        if (start_frame) begin
            pop       = 1'b1;
            state_n   = START;
            tx_n      = 1'b0;
            sh_n      = rdata;
            presc_l_n = prescale;
            cnt_n     = prescale;
`ifdef UART_TX_PARITY_EN
            par_en_l_n  = parity_en;
            par_bit_l_n = (^rdata) ^ parity_odd;
`endif
        end
    end

    // Serialiser state; tx idles high straight out of reset.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= IDLE;
            cnt     <= '0;
            presc_l <= '0;
            idx     <= '0;
            sh      <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_l  <= 1'b0;
            par_bit_l <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            presc_l <= presc_l_n;
            idx     <= idx_n;
            sh      <= sh_n;
            tx      <= tx_n;
            busy    <= (state_n != IDLE);
`ifdef UART_TX_PARITY_EN
            par_en_l  <= par_en_l_n;
            par_bit_l <= par_bit_l_n;
`endif
        end
    end

    // Sticky overflow on a write into a full FIFO; clear wins.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)     ovf <= 1'b0;
        else if (ovf_clr) ovf <= 1'b0;
        else if (wr && full) ovf <= 1'b1;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: frames are predicted at enqueue time
// and a line monitor checks every cycle of every frame on tx.
module tb_uart_tx_fifo;

    logic        HCLK = 1'b0, HRESETn = 1'b0;
    logic        en = 1'b0, wr = 1'b0, ovf_clr = 1'b0;
    logic        parity_en = 1'b0, parity_odd = 1'b0;
    logic [15:0] prescale = '0;
    logic [7:0]  wdata = '0;
    logic        tx, full, empty, busy, ovf;
    logic [4:0]  level;

    int checks = 0, failures = 0;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam bit PAR_BUILD = 1'b0;
`endif

    uart_tx_fifo #(.FIFO_DEPTH(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .en(en), .prescale(prescale),
        .wdata(wdata), .wr(wr), .ovf_clr(ovf_clr), .parity_en(parity_en),
        .parity_odd(parity_odd), .tx(tx), .full(full), .empty(empty),
        .level(level), .busy(busy), .ovf(ovf)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [7:0] data;
        int         per;
        bit         par;
        bit         pbit;
    } frame_t;

    frame_t exp_q[$];

    function automatic frame_t mk(input logic [7:0] d);
        frame_t f;
        f.data = d;
        f.per  = int'(prescale) + 1;
        f.par  = PAR_BUILD && parity_en;
        f.pbit = (^d) ^ parity_odd;
        return f;
    endfunction

    function automatic int nbits(input frame_t f);
        return f.par ? 11 : 10;
    endfunction

    // Bit b of the frame on the line: start, 8 data LSB first, [parity], stop.
    function automatic logic exp_bit(input frame_t f, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return f.data[b-1];
        if (b == 9 && f.par) return f.pbit;
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- line monitor ----------------
    bit         in_frame = 1'b0;
    logic       prev_tx = 1'b1;
    int         mcyc, ferr;
    frame_t     cur;
    logic [7:0] got;

    always @(negedge HCLK) begin
        if (!HRESETn) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame && tx === 1'b0) begin
                if (exp_q.size() == 0) begin
                    if (prev_tx !== 1'b0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_frame actual=start_bit required=idle_line");
                    end
                end else begin
                    cur = exp_q.pop_front();
                    in_frame = 1'b1;
                    mcyc = 0;
                    ferr = 0;
                    got = '0;
                end
            end
            if (in_frame) begin
                int b;
                b = mcyc / cur.per;
                if (tx !== exp_bit(cur, b) || busy !== 1'b1) ferr++;
                if (b >= 1 && b <= 8 && (mcyc % cur.per) == cur.per / 2) got[b-1] = tx;
                mcyc++;
                if (mcyc == nbits(cur) * cur.per) begin
                    checks++;
                    if (ferr != 0) begin
                        failures++;
                        $display("FAIL frame actual=%02h(bad_cycles=%0d) required=%02h per=%0d par=%0d",
                                 got, ferr, cur.data, cur.per, cur.par);
                    end
                    in_frame = 1'b0;
                end
            end
        end
        prev_tx = tx;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic wr_byte(input logic [7:0] b, input bit accept);
        wdata = b;
        wr = 1'b1;
        tick();
        wr = 1'b0;
        if (accept) exp_q.push_back(mk(b));
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((busy || !empty || in_frame) && n < bound) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(n < bound), 32'd1);
    endtask

    // Waits for busy to rise, then counts consecutive busy cycles.
    task automatic measure_busy(input string name, input int expv);
        int n = 0, span;
        while (!busy && n < 50) begin
            tick();
            n++;
        end
        span = busy ? 1 : 0;
        n = 0;
        while (busy && n < expv + 100) begin
            tick();
            n++;
            if (busy) span++;
        end
        chk(name, 32'(span), 32'(expv));
    endtask

    initial begin
        int cnt_m, nb;
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_m, nb, span, n;
        logic [7:0] b;
        nb = PAR_BUILD ? 11 : 10;

        // reset state
        tick(); tick();
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        HRESETn = 1'b1;
        tick();

        // single 'A' at prescale 15, first-frame latency
        prescale = 16'd15;
        en = 1'b1;
        wr_byte(8'h41, 1'b1);
        chk("lat_level", 32'(level), 32'd1);
        chk("lat_busy_k", 32'(busy), 32'd0);
        chk("lat_tx_k", 32'(tx), 32'd1);
        tick();
        chk("lat_busy_k1", 32'(busy), 32'd1);
        chk("lat_tx_k1", 32'(tx), 32'd0);
        measure_busy("span_A", 160);
        wait_idle(400);

        // fill with en=0, overflow, clear
        en = 1'b0;
        prescale = 16'd3;
        cnt_m = 0;
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            wr_byte(b, cnt_m < 16);
            if (cnt_m < 16) cnt_m++;
            chk("fill_level", 32'(level), 32'(cnt_m));
            if (i == 15) begin
                chk("fill_full", 32'(full), 32'd1);
                chk("fill_ovf_pre", 32'(ovf), 32'd0);
            end
            if (i == 16) chk("fill_ovf", 32'(ovf), 32'd1);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(ovf), 32'd0);
        // clear has priority over a simultaneous dropped write
        wdata = 8'hEE; wr = 1'b1; ovf_clr = 1'b1;
        tick();
        wr = 1'b0; ovf_clr = 1'b0;
        chk("ovf_clr_prio", 32'(ovf), 32'd0);
        chk("full_level", 32'(level), 32'd16);

        // drain back-to-back
        en = 1'b1;
        measure_busy("b2b_span", 16 * 10 * 4);
        chk("b2b_empty", 32'(empty), 32'd1);
        chk("b2b_level", 32'(level), 32'd0);
        wait_idle(200);

        // parity even/odd on 'A'
        prescale = 16'd2;
        parity_en = 1'b1;
        parity_odd = 1'b0;
        wr_byte(8'h41, 1'b1);
        measure_busy("par_even_span", nb * 3);
        wait_idle(200);
        parity_odd = 1'b1;
        wr_byte(8'h41, 1'b1);
        measure_busy("par_odd_span", nb * 3);
        wait_idle(200);
        parity_en = 1'b0;
        parity_odd = 1'b0;

        // prescale 0: one cycle per bit
        prescale = 16'd0;
        wr_byte(8'hFF, 1'b1);
        wr_byte(8'h00, 1'b1);
        measure_busy("p0_span", 20);
        wait_idle(100);

        // randomized batches
        for (int r = 0; r < 8; r++) begin
            prescale = 16'($urandom_range(0, 7));
            parity_en = 1'($urandom);
            parity_odd = 1'($urandom);
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) wr_byte(8'($urandom), 1'b1);
            wait_idle(2000);
        end
        parity_en = 1'b0;

        // prescale change mid-frame has no effect on the current frame
        prescale = 16'd5;
        wr_byte(8'hA5, 1'b1);
        tick();
        span = 1;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
            if (busy) span++;
            if (span == 30) prescale = 16'd2;
        end
        chk("midframe_span", 32'(span), 32'd60);
        wait_idle(200);

        // reset mid-frame
        prescale = 16'd5;
        wr_byte(8'h3C, 1'b1);
        wr_byte(8'hC3, 1'b1);
        repeat (30) tick();
        HRESETn = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_mid_tx", 32'(tx), 32'd1);
        chk("rst_mid_level", 32'(level), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        tick(); tick();
        HRESETn = 1'b1;
        repeat (150) tick();
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_tx", 32'(tx), 32'd1);
        chk("post_rst_level", 32'(level), 32'd0);

        wait_idle(200);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
